// File: rtl/gppcu_host_pkg.sv
// Shared definitions for the GPPCU host command path: wparam opcodes, iCMD field
// positions and the sequencer state encoding.
package gppcu_host_pkg;

    localparam logic [6:0] OPR_INSTR = 7'd0;
    localparam logic [6:0] OPR_RDLOC = 7'd1;
    localparam logic [6:0] OPR_WRLOC = 7'd2;
    localparam logic [6:0] OPR_WRGLB = 7'd3;
    localparam logic [6:0] OPR_STAT  = 7'd4;

    localparam int CMD_OPCLK_BIT = 31;
    localparam int CMD_WP_MSB    = 30;
    localparam int CMD_WP_LSB    = 24;
    localparam int CMD_LP_MSB    = 23;
    localparam int CMD_LP_LSB    = 16;
    localparam int CMD_OP_MSB    = 15;
    localparam int CMD_OP_LSB    = 0;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_SPACE = 3'd1,
        ST_SETUP      = 3'd2,
        ST_HIGH       = 3'd3,
        ST_HOLD       = 3'd4,
        ST_RESP       = 3'd5
    } seq_state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/gppcu_host_cmd_seq.sv
// Host command sequencer: turns one host request into a setup/pulse/hold op-clock
// sequence on the queue's iCMD/iDATA pins and returns read data for read ops.
module gppcu_host_cmd_seq
    import gppcu_host_pkg::*;
#(
    parameter int SETUP_CYC  = 2,
    parameter int PULSE_CYC  = 2,
    parameter int HOLD_CYC   = 2,
    parameter int TIMEOUT_BW = 16
) (
    input  logic        iACLK,
    input  logic        inRST,
    input  logic        iREQ_VALID,
    output logic        oREQ_READY,
    input  logic [30:0] iREQ_CMD,
    input  logic [31:0] iREQ_DATA,
    output logic        oRSP_VALID,
    output logic [31:0] oRSP_DATA,
    output logic        oERR,
    input  logic        iERR_CLR,
    output logic        oBUSY,
    output logic [31:0] oCMD,
    output logic [31:0] oDATA,
    input  logic [31:0] iQDATA,
    input  logic        iQFULL
);

    localparam int PH_W = $clog2(max3(SETUP_CYC, PULSE_CYC, HOLD_CYC) + 1);

    localparam logic [PH_W-1:0]       PH_ONE   = PH_W'(1);
    localparam logic [PH_W-1:0]       SETUP_LD = PH_W'(SETUP_CYC);
    localparam logic [PH_W-1:0]       PULSE_LD = PH_W'(PULSE_CYC);
    localparam logic [PH_W-1:0]       HOLD_LD  = PH_W'(HOLD_CYC);
    localparam logic [TIMEOUT_BW-1:0] TMO_ONE  = TIMEOUT_BW'(1);
    // Last wait cycle before giving up: the counter starts at 0 on entry.
    localparam logic [TIMEOUT_BW-1:0] TMO_LAST = {TIMEOUT_BW{1'b1}} - TMO_ONE;

    seq_state_e             state_q, state_d;
    logic [PH_W-1:0]        phase_q, phase_d;
    logic [TIMEOUT_BW-1:0]  tmo_q, tmo_d;
    logic [30:0]            cmd_q, cmd_d;
    logic [31:0]            data_q, data_d;
    logic                   opclk_q, opclk_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic [31:0]            rsp_data_q, rsp_data_d;
    logic                   err_q, err_d;

    logic [6:0] wp_in;
    logic [6:0] wp_cur;
    logic       cur_is_read;
    logic       err_set;

    assign wp_in       = iREQ_CMD[CMD_WP_MSB:CMD_WP_LSB];
    assign wp_cur      = cmd_q[CMD_WP_MSB:CMD_WP_LSB];
    assign cur_is_read = (wp_cur == OPR_RDLOC) || (wp_cur == OPR_STAT);

    always_comb begin
        // NOTE: every _d starts from its _q (or an idle value) so no branch of the
        // case below can leave a signal unassigned and infer a latch.
        state_d     = state_q;
        phase_d     = phase_q;
        tmo_d       = tmo_q;
        cmd_d       = cmd_q;
        data_d      = data_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        err_set     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (iREQ_VALID) begin
                    cmd_d  = iREQ_CMD;
                    data_d = iREQ_DATA;
                    if (wp_in > OPR_STAT) begin
                        err_set = 1'b1;
                    end else if ((wp_in == OPR_INSTR) && iQFULL) begin
                        state_d = ST_WAIT_SPACE;
                        tmo_d   = '0;
                    end else begin
                        state_d = ST_SETUP;
                        phase_d = SETUP_LD;
                    end
                end
            end
            ST_WAIT_SPACE: begin
                if (!iQFULL) begin
                    state_d = ST_SETUP;
                    phase_d = SETUP_LD;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = ST_IDLE;
                    err_set = 1'b1;
                end else begin
                    tmo_d = tmo_q + TMO_ONE;
                end
            end
            ST_SETUP: begin
                if (phase_q == PH_ONE) begin
                    state_d = ST_HIGH;
                    phase_d = PULSE_LD;
                end else begin
                    phase_d = phase_q - PH_ONE;
                end
            end
            ST_HIGH: begin
                if (phase_q == PH_ONE) begin
                    state_d = ST_HOLD;
                    phase_d = HOLD_LD;
                end else begin
                    phase_d = phase_q - PH_ONE;
                end
            end
            ST_HOLD: begin
                if (phase_q == PH_ONE) begin
                    state_d = cur_is_read ? ST_RESP : ST_IDLE;
                end else begin
                    phase_d = phase_q - PH_ONE;
                end
            end
            ST_RESP: begin
                rsp_valid_d = 1'b1;
                rsp_data_d  = iQDATA;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Op-clock comes straight from a flop so the queue never sees a glitch.
        opclk_d = (state_d == ST_HIGH);
        err_d   = err_set ? 1'b1 : (iERR_CLR ? 1'b0 : err_q);
    end

    always_ff @(posedge iACLK or negedge inRST) begin
        if (!inRST) begin
            state_q     <= ST_IDLE;
            phase_q     <= '0;
            tmo_q       <= '0;
            cmd_q       <= '0;
            data_q      <= '0;
            opclk_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values.
            state_q     <= state_d;
            phase_q     <= phase_d;
            tmo_q       <= tmo_d;
            cmd_q       <= cmd_d;
            data_q      <= data_d;
            opclk_q     <= opclk_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            err_q       <= err_d;
        end
    end

    assign oREQ_READY = (state_q == ST_IDLE);
    assign oBUSY      = (state_q != ST_IDLE);
    assign oCMD       = {opclk_q, cmd_q};
    assign oDATA      = data_q;
    assign oRSP_VALID = rsp_valid_q;
    assign oRSP_DATA  = rsp_data_q;
    assign oERR       = err_q;

endmodule

// File: tb/tb_gppcu_host_cmd_seq.sv
// Scoreboard bench for gppcu_host_cmd_seq with a small behavioural queue model.
module tb_gppcu_host_cmd_seq;
    import gppcu_host_pkg::*;

    logic        iACLK = 1'b0;
    logic        inRST;
    logic        iREQ_VALID;
    logic        oREQ_READY;
    logic [30:0] iREQ_CMD;
    logic [31:0] iREQ_DATA;
    logic        oRSP_VALID;
    logic [31:0] oRSP_DATA;
    logic        oERR;
    logic        iERR_CLR;
    logic        oBUSY;
    logic [31:0] oCMD;
    logic [31:0] oDATA;
    logic [31:0] iQDATA;
    logic        iQFULL;

    gppcu_host_cmd_seq #(
        .SETUP_CYC (2),
        .PULSE_CYC (2),
        .HOLD_CYC  (2),
        .TIMEOUT_BW(4)
    ) dut (
        .iACLK     (iACLK),
        .inRST     (inRST),
        .iREQ_VALID(iREQ_VALID),
        .oREQ_READY(oREQ_READY),
        .iREQ_CMD  (iREQ_CMD),
        .iREQ_DATA (iREQ_DATA),
        .oRSP_VALID(oRSP_VALID),
        .oRSP_DATA (oRSP_DATA),
        .oERR      (oERR),
        .iERR_CLR  (iERR_CLR),
        .oBUSY     (oBUSY),
        .oCMD      (oCMD),
        .oDATA     (oDATA),
        .iQDATA    (iQDATA),
        .iQFULL    (iQFULL)
    );

    always #5 iACLK = ~iACLK;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;
    int rise_cnt     = 0;
    int exp_pushes   = 0;

    logic [62:0] exp_cmd_q[$];
    logic [31:0] exp_rsp_q[$];
    logic [62:0] mon_cmd;
    logic [31:0] mon_rsp;
    logic [31:0] loc_mem[256];
    logic [15:0] m_tail = '0;

    always @(posedge iACLK) cyc++;

    // Op-clock monitor: checks the fields the queue latches, then updates the queue model.
    always @(posedge oCMD[CMD_OPCLK_BIT]) begin
        rise_cnt++;
        tests_run++;
        if (exp_cmd_q.size() == 0) begin
            tests_failed++;
            $display("FAIL op_clk_unexpected got cmd=%h data=%h", oCMD, oDATA);
        end else begin
            mon_cmd = exp_cmd_q.pop_front();
            if ({oCMD[30:0], oDATA} !== mon_cmd) begin
                tests_failed++;
                $display("FAIL op_clk_fields got %h_%h exp %h_%h",
                         oCMD[30:0], oDATA, mon_cmd[62:32], mon_cmd[31:0]);
            end
        end
        case (oCMD[CMD_WP_MSB:CMD_WP_LSB])
            OPR_INSTR: m_tail = m_tail + 16'd1;
            OPR_RDLOC: iQDATA = loc_mem[oCMD[CMD_LP_MSB:CMD_LP_LSB]];
            OPR_WRLOC: loc_mem[oCMD[CMD_LP_MSB:CMD_LP_LSB]] = oDATA;
            OPR_STAT:  iQDATA = {16'h0000, m_tail};
            default:   ;
        endcase
    end

    // Response monitor: every oRSP_VALID cycle must consume exactly one expectation.
    always @(negedge iACLK) begin
        if (inRST && oRSP_VALID) begin
            tests_run++;
            if (exp_rsp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL rsp_unexpected got %h", oRSP_DATA);
            end else begin
                mon_rsp = exp_rsp_q.pop_front();
                if (oRSP_DATA !== mon_rsp) begin
                    tests_failed++;
                    $display("FAIL rsp_data got %h exp %h", oRSP_DATA, mon_rsp);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s got %h exp %h", name, got, exp);
        end
    endtask

    // Caller is at a negedge; returns at the negedge after the accepting edge, VALID still high.
    task automatic submit(input logic [30:0] c, input logic [31:0] d, input bit pulse,
                          input bit has_rsp, input logic [31:0] rsp, output int acc);
        int k;
        if (pulse)   exp_cmd_q.push_back({c, d});
        if (has_rsp) exp_rsp_q.push_back(rsp);
        iREQ_VALID = 1'b1;
        iREQ_CMD   = c;
        iREQ_DATA  = d;
        k = 0;
        while (!oREQ_READY && k < 200) begin
            @(negedge iACLK);
            k++;
        end
        tests_run++;
        if (!oREQ_READY) begin
            tests_failed++;
            $display("FAIL ready_timeout got ready=%b exp 1", oREQ_READY);
        end
        acc = cyc;
        @(negedge iACLK);
    endtask

    task automatic idle_req();
        iREQ_VALID = 1'b0;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (oBUSY && n < 300) begin
            n++;
            @(negedge iACLK);
        end
    endtask

    task automatic settle();
        repeat (3) @(negedge iACLK);
    endtask

    task automatic clear_err();
        iERR_CLR = 1'b1;
        @(negedge iACLK);
        iERR_CLR = 1'b0;
        chk("err_cleared", {31'd0, oERR}, 32'd0);
    endtask

    task automatic test_reset();
        inRST      = 1'b0;
        iREQ_VALID = 1'b0;
        iREQ_CMD   = '0;
        iREQ_DATA  = '0;
        iERR_CLR   = 1'b0;
        iQFULL     = 1'b0;
        iQDATA     = '0;
        for (int i = 0; i < 256; i++) loc_mem[i] = '0;
        repeat (3) @(negedge iACLK);
        chk("reset_cmd", oCMD, 32'd0);
        chk("reset_data", oDATA, 32'd0);
        chk("reset_rsp", {oRSP_DATA[30:0], oRSP_VALID}, 32'd0);
        chk("reset_flags", {29'd0, oERR, oBUSY, oREQ_READY}, 32'd1);
        inRST = 1'b1;
        @(negedge iACLK);
    endtask

    task automatic test_wr_local();
        int acc, n, r0;
        r0 = rise_cnt;
        submit({OPR_WRLOC, 8'd1, 16'd5}, 32'h0000_A5A5, 1'b1, 1'b0, '0, acc);
        idle_req();
        count_busy(n);
        chk("wr_busy_cycles", n, 32'd6);
        chk("wr_rises", rise_cnt - r0, 32'd1);
        settle();
        chk("wr_cmd_held", oCMD, 32'h0201_0005);
        chk("wr_data_held", oDATA, 32'h0000_A5A5);
    endtask

    task automatic test_rd_local();
        int acc, n;
        submit({OPR_RDLOC, 8'd1, 16'd0}, 32'd0, 1'b1, 1'b1, 32'h0000_A5A5, acc);
        idle_req();
        count_busy(n);
        chk("rd_busy_cycles", n, 32'd7);
        settle();
        chk("rd_rsp_drained", exp_rsp_q.size(), 32'd0);
    endtask

    task automatic test_full_wait();
        int acc, n, r0;
        r0 = rise_cnt;
        iQFULL = 1'b1;
        submit({OPR_INSTR, 8'd0, 16'd0}, 32'h1234_5678, 1'b1, 1'b0, '0, acc);
        idle_req();
        repeat (10) @(negedge iACLK);
        chk("full_no_rise", rise_cnt - r0, 32'd0);
        chk("full_still_busy", {31'd0, oBUSY}, 32'd1);
        iQFULL = 1'b0;
        count_busy(n);
        chk("full_one_rise", rise_cnt - r0, 32'd1);
        chk("full_no_err", {31'd0, oERR}, 32'd0);
        exp_pushes++;
        settle();
    endtask

    task automatic test_timeout();
        int acc, n, r0;
        r0 = rise_cnt;
        iQFULL = 1'b1;
        submit({OPR_INSTR, 8'd0, 16'd0}, 32'hDEAD_BEEF, 1'b0, 1'b0, '0, acc);
        idle_req();
        count_busy(n);
        chk("tmo_busy_cycles", n, 32'd15);
        chk("tmo_err", {31'd0, oERR}, 32'd1);
        iQFULL = 1'b0;
        settle();
        chk("tmo_no_rise", rise_cnt - r0, 32'd0);
        clear_err();
    endtask

    task automatic test_bad_wparam();
        int acc, r0;
        r0 = rise_cnt;
        submit({7'd9, 8'd0, 16'd0}, 32'h0BAD_0BAD, 1'b0, 1'b0, '0, acc);
        idle_req();
        chk("bad_err", {31'd0, oERR}, 32'd1);
        chk("bad_ready_next", {30'd0, oREQ_READY, oBUSY}, 32'd2);
        settle();
        chk("bad_no_rise", rise_cnt - r0, 32'd0);
        clear_err();
    endtask

    task automatic test_rd_status();
        int acc, n;
        submit({OPR_STAT, 8'd0, 16'd0}, 32'd0, 1'b1, 1'b1, exp_pushes, acc);
        idle_req();
        count_busy(n);
        chk("stat_busy_cycles", n, 32'd7);
        settle();
        chk("stat_rsp_drained", exp_rsp_q.size(), 32'd0);
    endtask

    task automatic test_back_to_back();
        int a0, a1, a2, a3, n;
        submit({OPR_WRLOC, 8'd2, 16'h0011}, 32'h0000_1111, 1'b1, 1'b0, '0, a0);
        submit({OPR_WRGLB, 8'd7, 16'h0022}, 32'h0000_2222, 1'b1, 1'b0, '0, a1);
        submit({OPR_RDLOC, 8'd2, 16'h0033}, 32'd0, 1'b1, 1'b1, 32'h0000_1111, a2);
        submit({OPR_WRLOC, 8'd3, 16'h0044}, 32'h0000_4444, 1'b1, 1'b0, '0, a3);
        idle_req();
        count_busy(n);
        settle();
        chk("b2b_wr_period", a1 - a0, 32'd7);
        chk("b2b_wrg_period", a2 - a1, 32'd7);
        chk("b2b_rd_period", a3 - a2, 32'd8);
        chk("b2b_cmd_drained", exp_cmd_q.size(), 32'd0);
        chk("b2b_rsp_drained", exp_rsp_q.size(), 32'd0);
    endtask

    task automatic test_reset_mid_pulse();
        int acc, k;
        submit({OPR_WRLOC, 8'd4, 16'h0055}, 32'h0000_5555, 1'b1, 1'b0, '0, acc);
        idle_req();
        k = 0;
        while (!oCMD[CMD_OPCLK_BIT] && k < 20) begin
            @(negedge iACLK);
            k++;
        end
        chk("midrst_pulse_seen", {31'd0, oCMD[CMD_OPCLK_BIT]}, 32'd1);
        #1 inRST = 1'b0;
        #1;
        chk("midrst_opclk_low", {31'd0, oCMD[CMD_OPCLK_BIT]}, 32'd0);
        chk("midrst_cmd", oCMD, 32'd0);
        chk("midrst_data", oDATA, 32'd0);
        chk("midrst_flags", {29'd0, oERR, oBUSY, oREQ_READY}, 32'd1);
        @(negedge iACLK);
        inRST = 1'b1;
        settle();
        chk("midrst_ready_after", {31'd0, oREQ_READY}, 32'd1);
    endtask

    initial begin
        test_reset();
        test_wr_local();
        test_rd_local();
        test_full_wait();
        test_timeout();
        test_bad_wparam();
        test_rd_status();
        test_back_to_back();
        test_reset_mid_pulse();
        chk("final_cmd_drained", exp_cmd_q.size(), 32'd0);
        chk("final_rsp_drained", exp_rsp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
